// File: rtl/pipelined_rd_addsub_if.sv
// Operand/result handshake bundle for pipelined_rd_addsub.
// Carries the optional ovf result bit when RD_OVERFLOW_EN is defined.
interface pipelined_rd_addsub_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
`ifdef RD_OVERFLOW_EN
  logic             ovf;

  modport master (output A, B, cin, sub, in_valid, out_ready,
                  input  in_ready, S, cout, out_valid, ovf);
  modport slave  (input  A, B, cin, sub, in_valid, out_ready,
                  output in_ready, S, cout, out_valid, ovf);
`else
  modport master (output A, B, cin, sub, in_valid, out_ready,
                  input  in_ready, S, cout, out_valid);
  modport slave  (input  A, B, cin, sub, in_valid, out_ready,
                  output in_ready, S, cout, out_valid);
`endif
endinterface

// File: rtl/pipelined_rd_addsub.sv
// Pipelined recursive-doubling (Kogge-Stone) adder/subtractor, latency log2(WIDTH)+2.
// Define RD_OVERFLOW_EN to add the signed-overflow output ovf.
module pipelined_rd_addsub #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_rd_addsub_if.slave bus
);
  localparam int LOG2W = $clog2(WIDTH);

  // Status is tracked per position 0..WIDTH: position 0 is the carry-in slot,
  // position i+1 is operand bit i. p=0 at position 0 makes groups reaching it final.
  logic [LOG2W:0]            vld_q, vld_d;
  logic [LOG2W:0][WIDTH:0]   g_q, g_d, p_q, p_d;
  logic [LOG2W:0][WIDTH-1:0] hs_q, hs_d;
  logic [LOG2W:1][WIDTH:0]   gc, pc;
  logic [WIDTH-1:0]          b_eff, s_q, s_d;
  logic                      out_vld_q, out_vld_d;
  logic                      cout_q, cout_d, cout_c;
  logic                      advance;
  logic                      unused_p;
`ifdef RD_OVERFLOW_EN
  logic                      ovf_q, ovf_d;
`endif

  assign advance      = bus.out_ready | ~out_vld_q;
  assign bus.in_ready = advance;
  assign bus.out_valid = out_vld_q;
  assign bus.S        = s_q;
  assign bus.cout     = cout_q;
`ifdef RD_OVERFLOW_EN
  assign bus.ovf      = ovf_q;
`endif

  assign b_eff = bus.sub ? ~bus.B : bus.B;

  for (genvar k = 1; k <= LOG2W; k++) begin : g_pfx
    localparam int D = 1 << (k - 1);
    assign gc[k] = {g_q[k-1][WIDTH:D] | (p_q[k-1][WIDTH:D] & g_q[k-1][WIDTH-D:0]),
                    g_q[k-1][D-1:0]};
    assign pc[k] = {p_q[k-1][WIDTH:D] & p_q[k-1][WIDTH-D:0], p_q[k-1][D-1:0]};
  end

  // The top position spans bits 0..WIDTH-1 only; fold in the carry-in slot here.
  assign cout_c   = g_q[LOG2W][WIDTH] | (p_q[LOG2W][WIDTH] & g_q[LOG2W][0]);
  assign unused_p = ^p_q[LOG2W][WIDTH-1:0];

  always_comb begin
    vld_d     = vld_q;
    g_d       = g_q;
    p_d       = p_q;
    hs_d      = hs_q;
    out_vld_d = out_vld_q;
    s_d       = s_q;
    cout_d    = cout_q;
`ifdef RD_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    if (advance) begin
      vld_d          = {vld_q[LOG2W-1:0], bus.in_valid};
      g_d[0]         = {bus.A & b_eff, bus.sub | bus.cin};
      p_d[0]         = {bus.A ^ b_eff, 1'b0};
      g_d[LOG2W:1]   = gc;
      p_d[LOG2W:1]   = pc;
      hs_d           = {hs_q[LOG2W-1:0], bus.A ^ b_eff};
      out_vld_d      = vld_q[LOG2W];
      s_d            = hs_q[LOG2W] ^ g_q[LOG2W][WIDTH-1:0];
      cout_d         = cout_c;
`ifdef RD_OVERFLOW_EN
      ovf_d          = g_q[LOG2W][WIDTH-1] ^ cout_c;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      g_q       <= '0;
      p_q       <= '0;
      hs_q      <= '0;
      out_vld_q <= 1'b0;
      s_q       <= '0;
      cout_q    <= 1'b0;
`ifdef RD_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      vld_q     <= vld_d;
      g_q       <= g_d;
      p_q       <= p_d;
      hs_q      <= hs_d;
      out_vld_q <= out_vld_d;
      s_q       <= s_d;
      cout_q    <= cout_d;
`ifdef RD_OVERFLOW_EN
      ovf_q     <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_pipelined_rd_addsub.sv
// Directed-vector bench for pipelined_rd_addsub (WIDTH=32, latency 7).
module tb_pipelined_rd_addsub;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_rd_addsub_if #(.WIDTH(W)) bus();
  pipelined_rd_addsub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [W:0] res_q[$];

  // Completed transfers as {cout, S}; out_ready is stable by the falling edge.
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) res_q.push_back({bus.cout, bus.S});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb);
    bus.A = a; bus.B = b; bus.cin = ci; bus.sub = sb; bus.in_valid = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    bus.out_ready = 1'b1;
    drive(a, b, ci, sb);
    step;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step;
      lat++;
    end
    chk({tag, "_lat"}, lat, 7);
    chk({tag, "_s"}, bus.S, es);
    chk({tag, "_cout"}, bus.cout, ec);
`ifdef RD_OVERFLOW_EN
    chk({tag, "_ovf"}, bus.ovf, eo);
`else
    if (eo === 1'bx) $display("note: unexpected X expectation in %s", tag);
`endif
    step;
  endtask

  task automatic drain(input int n);
    int k;
    k = 0;
    while (res_q.size() < n && k < 40) begin
      step;
      k++;
    end
    repeat (10) step;
  endtask

  initial begin : main
    int sent, cyc, k;
    logic [W:0] exp3[3];
    rst = 1'b1;
    bus.A = '0; bus.B = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step; step;
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_s", bus.S, 0);
    chk("rst_cout", bus.cout, 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", bus.in_ready, 1);
    step;

    run_op("add_small", 32'd1200, 32'd1000, 1'b0, 1'b0, 32'd2200, 1'b0, 1'b0);
    run_op("add_mix", 32'h34CF36CD, 32'h9C8F0C6B, 1'b0, 1'b0, 32'hD15E4338, 1'b0, 1'b0);
    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("add_cin", 32'd1, 32'd2, 1'b1, 1'b0, 32'd4, 1'b0, 1'b0);
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("sub_pos_cin", 32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
    run_op("sub_ovf", 32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Back-to-back mode changes while earlier ops are still in flight.
    res_q.delete();
    bus.out_ready = 1'b1;
    drive(32'd5, 32'd7, 1'b0, 1'b1); step;
    drive(32'd3, 32'd4, 1'b0, 1'b0); step;
    drive(32'd7, 32'd5, 1'b0, 1'b1); step;
    bus.in_valid = 1'b0;
    drain(3);
    exp3[0] = {1'b0, 32'hFFFFFFFE};
    exp3[1] = {1'b0, 32'd7};
    exp3[2] = {1'b1, 32'd2};
    chk("mix_cnt", res_q.size(), 3);
    for (int i = 0; i < 3 && i < res_q.size(); i++) chk("mix_res", res_q[i], exp3[i]);

    // Ten ops at full rate with a three-cycle downstream stall mid-stream.
    res_q.delete();
    sent = 0;
    cyc = 0;
    while (sent < 10 && cyc < 60) begin
      drive(sent + 1, sent + 1, 1'b0, 1'b0);
      bus.out_ready = !(cyc >= 8 && cyc <= 10);
      #1;
      if (cyc >= 8 && cyc <= 10) begin
        chk("stall_rdy", bus.in_ready, 0);
        chk("stall_vld", bus.out_valid, 1);
        chk("stall_s", bus.S, 4);
      end
      if (bus.in_ready) sent++;
      step;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_sent", sent, 10);
    drain(10);
    chk("stream_cnt", res_q.size(), 10);
    for (int i = 0; i < 10 && i < res_q.size(); i++)
      chk("stream_res", res_q[i], 2 * (i + 1));

    // Reset with four ops in flight and one held at the output.
    res_q.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(100 + i, 1, 1'b0, 1'b0);
      step;
    end
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      step;
      k++;
    end
    chk("pre_rst_vld", bus.out_valid, 1);
    chk("pre_rst_s", bus.S, 101);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vld", bus.out_valid, 0);
    chk("mid_rst_s", bus.S, 0);
    chk("mid_rst_cout", bus.cout, 0);
    step; step;
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (15) step;
    chk("post_rst_stale", res_q.size(), 0);
    run_op("post_rst_op", 32'd9, 32'd9, 1'b0, 1'b0, 32'd18, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipelined_rd_addsub.md
PIPELINED_RD_ADDSUB -- requirements
Module: pipelined_rd_addsub

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; SHALL be a power of two, 4 to 64.
REQ-002 Derived constant: LOG2W = log2(WIDTH); pipeline latency L = LOG2W + 2 cycles (L = 7 at WIDTH=32).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: A  input  WIDTH  operand A.
REQ-006 Port: B  input  WIDTH  operand B.
REQ-007 Port: cin  input  1  carry-in; used in add mode only.
REQ-008 Port: sub  input  1  mode: 0 = A+B+cin, 1 = A-B (A + ~B + 1; cin ignored).
REQ-009 Port: in_valid  input  1  A/B/cin/sub valid this cycle.
REQ-010 Port: in_ready  output  1  block accepts an operation this cycle.
REQ-011 Port: S  output  WIDTH  result sum/difference.
REQ-012 Port: cout  output  1  carry-out; in subtract mode 1 = no borrow.
REQ-013 Port: out_valid  output  1  S/cout hold a valid result.
REQ-014 Port: out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-015 Carry computation SHALL use recursive doubling: stage 0 registers operands and forms per-bit kill/propagate/generate status (bit -1 seeded from carry-in); stages 1..LOG2W each combine status at distance 2^(k-1); final stage forms S = A^B'^carry and cout.
REQ-016 Each stage SHALL carry a valid bit; advance = out_ready | ~out_valid; all stages shift together when advance=1 and hold when advance=0.
REQ-017 in_ready SHALL equal advance; an operation is accepted iff in_valid & in_ready.
REQ-018 Results SHALL appear exactly L advancing cycles after acceptance, in acceptance order, each exactly once.
REQ-019 Bubbles (in_valid=0 while advancing) SHALL propagate as invalid slots; no bubble collapsing.
REQ-020 While out_valid & ~out_ready, S, cout and out_valid SHALL remain stable.
REQ-021 Full-rate throughput: one accepted operation per cycle while out_ready=1.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; wrap-around reported only via cout (and ovf when enabled).
REQ-023 sub SHALL be captured with its operands; mode changes between consecutive operations SHALL not affect in-flight operations.

Reset
REQ-024 rst=1 SHALL immediately clear all stage valid bits; out_valid=0, S=0, cout=0 (and ovf=0 when enabled).
REQ-025 Reset mid-operation SHALL discard all in-flight operations; none emerge after rst deasserts.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro RD_OVERFLOW_EN defined: extra output port ovf (1 bit) SHALL report two's-complement signed overflow of the selected operation, pipelined alongside S.
REQ-028 RD_OVERFLOW_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=32, out_ready=1 unless stated)
REQ-029 Add 1200+1000, cin=0 -> S=2200, cout=0, out_valid 7 cycles after acceptance.
REQ-030 Add 0x34CF36CD+0x9C8F0C6B, cin=0 -> S=0xD15E4338, cout=0.
REQ-031 Add 0xFFFFFFFF+0x00000001 -> S=0, cout=1; with RD_OVERFLOW_EN, 0x7FFFFFFF+1 -> S=0x80000000, ovf=1.
REQ-032 Sub 5-7 -> S=0xFFFFFFFE, cout=0; then sub 7-5 -> S=2, cout=1; interleaved with add 3+4 -> 7.
REQ-033 Ten back-to-back ops 1+1..10+10, out_ready low 3 cycles mid-stream -> results 2..20 in order, no loss/duplication, output stable while stalled, in_ready=0 during stall.
REQ-034 Four ops in flight, rst pulsed -> out_valid=0 immediately, no stale results afterwards, next op 9+9 -> 18 after 7 cycles.
